// File: rtl/rds_pkg.sv
// Shared types and constants for the RDS message double-buffer controller.
package rds_pkg;

  localparam int unsigned RDS_BYTE_W          = 8;
  localparam int unsigned RDS_MSG_LEN_DEFAULT = 52;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2,
    ST_COPY    = 2'd3
  } rds_state_e;

endpackage

// File: rtl/rds_msg_ram.sv
// One RDS message bank: single write port, two combinational read ports.
module rds_msg_ram
  import rds_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [RDS_BYTE_W-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr0,
  output logic [RDS_BYTE_W-1:0] rd0_data_c,
  input  logic [ADDR_BITS-1:0]  raddr1,
  output logic [RDS_BYTE_W-1:0] rd1_data_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  // Contents are deliberately not reset.
  logic [RDS_BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd0_data_c = mem[raddr0];
  assign rd1_data_c = mem[raddr1];

endmodule

// File: rtl/rds_msg_ctrl.sv
// Double-buffered RDS message store: host fills the shadow bank, commit swaps at message wrap.
// Optional RDS_MSG_READBACK_EN adds a registered host read port on the active bank.
module rds_msg_ctrl
  import rds_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 6,
  parameter int unsigned RDS_MSG_LEN = RDS_MSG_LEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [ADDR_BITS-1:0]  host_wr_addr,
  input  logic [RDS_BYTE_W-1:0] host_wr_data,
  input  logic [ADDR_BITS-1:0]  host_len,
  input  logic                  host_commit,
  output logic                  commit_pending,
  output logic                  swap_done,
  output logic                  commit_err,
`ifdef RDS_MSG_READBACK_EN
  input  logic [ADDR_BITS-1:0]  host_rd_addr,
  output logic [RDS_BYTE_W-1:0] host_rd_data,
`endif
  input  logic [ADDR_BITS-1:0]  rds_addr,
  output logic [RDS_BYTE_W-1:0] rds_data,
  output logic [ADDR_BITS-1:0]  rds_msg_len,
  output logic                  active_bank
);

  rds_state_e           state_q, state_d;
  logic                 active_bank_d;
  logic [ADDR_BITS-1:0] len_latch_q, len_latch_d;
  logic [ADDR_BITS-1:0] msg_len_d;
  logic [ADDR_BITS-1:0] copy_cnt_q, copy_cnt_d;
  logic [ADDR_BITS-1:0] prev_addr_q;
  logic                 ready_d, pending_d, swap_done_d, commit_err_d;

  logic                  wrap_c, host_we_c, copy_we_c, wr_en_c;
  logic [ADDR_BITS-1:0]  waddr_c, aux_addr_c;
  logic [RDS_BYTE_W-1:0] wdata_c;
  logic [RDS_BYTE_W-1:0] rd0_data_c [2];
  logic [RDS_BYTE_W-1:0] rd1_data_c [2];

  // Wrap is the modulator returning to byte 0 from anywhere else.
  assign wrap_c    = (rds_addr == '0) && (prev_addr_q != '0);
  assign host_we_c = host_wr_valid && host_wr_ready;
  assign copy_we_c = (state_q == ST_COPY);
  assign wr_en_c   = host_we_c || copy_we_c;
  assign waddr_c   = copy_we_c ? copy_cnt_q : host_wr_addr;
  assign wdata_c   = copy_we_c ? rd1_data_c[active_bank] : host_wr_data;

  // Only the shadow bank (not active) is ever written.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    rds_msg_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
      .clk       (clk),
      .we        (wr_en_c && (active_bank != 1'(b))),
      .waddr     (waddr_c),
      .wdata     (wdata_c),
      .raddr0    (rds_addr),
      .rd0_data_c(rd0_data_c[b]),
      .raddr1    (aux_addr_c),
      .rd1_data_c(rd1_data_c[b])
    );
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank;
    len_latch_d   = len_latch_q;
    msg_len_d     = rds_msg_len;
    copy_cnt_d    = copy_cnt_q;
    swap_done_d   = 1'b0;
    commit_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (host_commit) begin
          if (host_len != '0) begin
            len_latch_d = host_len;
            state_d     = ST_PENDING;
          end else begin
            commit_err_d = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if (wrap_c) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        active_bank_d = ~active_bank;
        msg_len_d     = len_latch_q;
        swap_done_d   = 1'b1;
        copy_cnt_d    = '0;
        state_d       = ST_COPY;
      end
      ST_COPY: begin
        copy_cnt_d = copy_cnt_q + ADDR_BITS'(1);
        if (copy_cnt_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d   = (state_d == ST_IDLE);
    pending_d = (state_d == ST_PENDING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      active_bank    <= 1'b0;
      len_latch_q    <= '0;
      rds_msg_len    <= ADDR_BITS'(RDS_MSG_LEN);
      copy_cnt_q     <= '0;
      prev_addr_q    <= '0;
      rds_data       <= '0;
      host_wr_ready  <= 1'b0;
      commit_pending <= 1'b0;
      swap_done      <= 1'b0;
      commit_err     <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_bank    <= active_bank_d;
      len_latch_q    <= len_latch_d;
      rds_msg_len    <= msg_len_d;
      copy_cnt_q     <= copy_cnt_d;
      prev_addr_q    <= rds_addr;
      rds_data       <= rd0_data_c[active_bank];
      host_wr_ready  <= ready_d;
      commit_pending <= pending_d;
      swap_done      <= swap_done_d;
      commit_err     <= commit_err_d;
    end
  end

`ifdef RDS_MSG_READBACK_EN
  // The copy engine owns the second read port during COPY; readback holds its last value.
  assign aux_addr_c = copy_we_c ? copy_cnt_q : host_rd_addr;

  always_ff @(posedge clk) begin
    if (rst) host_rd_data <= '0;
    else if (!copy_we_c) host_rd_data <= rd1_data_c[active_bank];
  end
`else
  assign aux_addr_c = copy_cnt_q;
`endif

endmodule

// File: tb/tb_rds_msg_ctrl.sv
// Scoreboard bench for rds_msg_ctrl: directed stimulus queues expectations, a negedge monitor checks them.
module tb_rds_msg_ctrl;

  localparam int unsigned AW = 6;

  localparam int SIG_LEN   = 0;
  localparam int SIG_BANK  = 1;
  localparam int SIG_PEND  = 2;
  localparam int SIG_READY = 3;
  localparam int SIG_DATA  = 4;
  localparam int SIG_ERR   = 5;
  localparam int SIG_SWAPS = 6;
  localparam int SIG_ERRS  = 7;

  typedef struct {
    string name;
    int    sig;
    int    exp;
    int    due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_wr_valid;
  logic          host_wr_ready;
  logic [AW-1:0] host_wr_addr;
  logic [7:0]    host_wr_data;
  logic [AW-1:0] host_len;
  logic          host_commit;
  logic          commit_pending;
  logic          swap_done;
  logic          commit_err;
  logic [AW-1:0] rds_addr;
  logic [7:0]    rds_data;
  logic [AW-1:0] rds_msg_len;
  logic          active_bank;
`ifdef RDS_MSG_READBACK_EN
  logic [AW-1:0] host_rd_addr = '0;
  logic [7:0]    host_rd_data;
`endif

  rds_msg_ctrl #(.ADDR_BITS(AW), .RDS_MSG_LEN(52)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_len      (host_len),
    .host_commit   (host_commit),
    .commit_pending(commit_pending),
    .swap_done     (swap_done),
    .commit_err    (commit_err),
`ifdef RDS_MSG_READBACK_EN
    .host_rd_addr  (host_rd_addr),
    .host_rd_data  (host_rd_data),
`endif
    .rds_addr      (rds_addr),
    .rds_data      (rds_data),
    .rds_msg_len   (rds_msg_len),
    .active_bank   (active_bank)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_swaps = 0;
  int   n_errs = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(input int sig);
    case (sig)
      SIG_LEN:   return 32'(rds_msg_len);
      SIG_BANK:  return 32'(active_bank);
      SIG_PEND:  return 32'(commit_pending);
      SIG_READY: return 32'(host_wr_ready);
      SIG_DATA:  return 32'(rds_data);
      SIG_ERR:   return 32'(commit_err);
      SIG_SWAPS: return 32'(n_swaps);
      SIG_ERRS:  return 32'(n_errs);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: tally DUT pulses, then retire every expectation due this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (swap_done === 1'b1) n_swaps++;
    if (commit_err === 1'b1) n_errs++;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e   = exp_q.pop_front();
      act = get_sig(e.sig);
      n_cmp++;
      if (act !== 32'(e.exp)) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  task automatic expect_now(input string name, input int sig, input int val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = val;
    e.due  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [AW-1:0] len);
    host_commit = 1'b1;
    host_len    = len;
    step(1);
    host_commit = 1'b0;
  endtask

  // From PENDING: 12 -> 0 wraps, then sit on byte 3 through the SWAP edge.
  task automatic run_to_swap();
    rds_addr = 6'd12;
    step(1);
    rds_addr = 6'd0;
    step(1);
    rds_addr = 6'd3;
    step(1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && host_wr_ready !== 1'b1; i++) step(1);
    expect_now("copy_done_ready", SIG_READY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    host_wr_valid = 1'b0;
    host_wr_addr  = '0;
    host_wr_data  = '0;
    host_len      = '0;
    host_commit   = 1'b0;
    rds_addr      = 6'd5;

    // Reset
    step(3);
    expect_now("ready_in_reset", SIG_READY, 0);
    rst = 1'b0;
    step(1);
    expect_now("rst_len", SIG_LEN, 52);
    expect_now("rst_bank", SIG_BANK, 0);
    expect_now("rst_pending", SIG_PEND, 0);
    expect_now("rst_ready", SIG_READY, 1);

    // Write 0x41@3, then 0x5A@7 in the commit cycle
    host_wr_valid = 1'b1;
    host_wr_addr  = 6'd3;
    host_wr_data  = 8'h41;
    step(1);
    host_wr_addr  = 6'd7;
    host_wr_data  = 8'h5A;
    commit(6'd13);
    host_wr_valid = 1'b0;
    expect_now("pending_after_commit", SIG_PEND, 1);
    expect_now("ready_in_pending", SIG_READY, 0);
    expect_now("bank_before_wrap", SIG_BANK, 0);
    rds_addr = 6'd12;
    step(1);
    rds_addr = 6'd0;
    step(1);
    expect_now("pending_in_swap", SIG_PEND, 0);
    expect_now("bank_in_swap", SIG_BANK, 0);
    expect_now("no_swap_yet", SIG_SWAPS, 0);
    rds_addr = 6'd3;
    step(1);
    expect_now("bank_after_swap", SIG_BANK, 1);
    expect_now("len_after_swap", SIG_LEN, 13);
    expect_now("swap_pulse", SIG_SWAPS, 1);
    step(1);
    expect_now("data_addr3", SIG_DATA, 8'h41);
    rds_addr = 6'd7;
    step(1);
    expect_now("data_commit_cycle_write", SIG_DATA, 8'h5A);

    // Writes held during COPY must be refused
    host_wr_valid = 1'b1;
    host_wr_addr  = 6'd3;
    host_wr_data  = 8'hEE;
    step(1);
    expect_now("ready_copy_start", SIG_READY, 0);
    step(60);
    expect_now("ready_copy_end", SIG_READY, 0);
    step(1);
    expect_now("ready_after_64_copies", SIG_READY, 1);
    host_wr_valid = 1'b0;
    expect_now("swap_once", SIG_SWAPS, 1);

    // Swap back: bank 0 must hold the copied 0x41, not the blocked 0xEE
    rds_addr = 6'd5;
    commit(6'd20);
    expect_now("pending_second", SIG_PEND, 1);
    run_to_swap();
    expect_now("bank_second_swap", SIG_BANK, 0);
    expect_now("len_second_swap", SIG_LEN, 20);
    step(1);
    expect_now("copied_data_addr3", SIG_DATA, 8'h41);
    wait_idle();
    expect_now("swaps_two", SIG_SWAPS, 2);

    // Modulator stuck at 5: no wrap, no swap
    rds_addr = 6'd5;
    commit(6'd11);
    step(100);
    expect_now("stuck_pending", SIG_PEND, 1);
    expect_now("stuck_no_swap", SIG_SWAPS, 2);
    expect_now("stuck_bank", SIG_BANK, 0);

    // Release the wrap, then reset in the middle of COPY
    rds_addr = 6'd0;
    step(1);
    rds_addr = 6'd3;
    step(1);
    expect_now("bank_before_reset", SIG_BANK, 1);
    expect_now("len_before_reset", SIG_LEN, 11);
    step(10);
    rst = 1'b1;
    step(2);
    expect_now("ready_mid_reset", SIG_READY, 0);
    rst = 1'b0;
    rds_addr = 6'd5;
    step(1);
    expect_now("recover_bank", SIG_BANK, 0);
    expect_now("recover_len", SIG_LEN, 52);
    expect_now("recover_pending", SIG_PEND, 0);
    expect_now("recover_ready", SIG_READY, 1);

    // Commit errors and ignored commits
    commit(6'd0);
    expect_now("err_pulse", SIG_ERR, 1);
    expect_now("err_count", SIG_ERRS, 1);
    expect_now("err_no_pending", SIG_PEND, 0);
    expect_now("err_ready", SIG_READY, 1);
    step(1);
    expect_now("err_one_cycle", SIG_ERR, 0);
    commit(6'd9);
    commit(6'd0);
    expect_now("pending_ignores_zero", SIG_PEND, 1);
    expect_now("no_err_in_pending", SIG_ERRS, 1);
    commit(6'd30);
    step(1);
    expect_now("still_one_err", SIG_ERRS, 1);
    run_to_swap();
    expect_now("ignored_len", SIG_LEN, 9);
    expect_now("bank_third", SIG_BANK, 1);
    wait_idle();
    expect_now("swaps_total", SIG_SWAPS, 4);

    step(2);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rds_msg_ctrl.md
RDS_MSG_CTRL -- requirements
Module: rds_msg_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6, the RDS message RAM address width.
REQ-002 SHALL have parameter RDS_MSG_LEN, default 52, the message length in bytes loaded at reset.
REQ-003 SHALL have port clk, input, 1, the single clock, shared with the RDS modulator.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port host_wr_valid, input, 1, host byte-write request.
REQ-006 SHALL have port host_wr_ready, output, 1, write accepted when valid and ready are both high.
REQ-007 SHALL have port host_wr_addr, input, ADDR_BITS, shadow bank byte address.
REQ-008 SHALL have port host_wr_data, input, 8, shadow bank byte.
REQ-009 SHALL have port host_len, input, ADDR_BITS, new message length, captured on commit.
REQ-010 SHALL have port host_commit, input, 1, one-cycle request to publish the shadow bank.
REQ-011 SHALL have port commit_pending, output, 1, high while a commit waits for message wrap.
REQ-012 SHALL have port swap_done, output, 1, one-cycle pulse when the banks swap.
REQ-013 SHALL have port commit_err, output, 1, one-cycle pulse when a commit is rejected.
REQ-014 SHALL have port rds_addr, input, ADDR_BITS, modulator read address.
REQ-015 SHALL have port rds_data, output, 8, active bank byte at rds_addr.
REQ-016 SHALL have port rds_msg_len, output, ADDR_BITS, active message length to the modulator.
REQ-017 SHALL have port active_bank, output, 1, the bank currently read by the modulator.

Function
REQ-018 SHALL hold two banks of 2**ADDR_BITS bytes each; the bank other than active_bank is the shadow bank.
REQ-019 SHALL register rds_data every cycle from active_bank[rds_addr], with 1-cycle latency.
REQ-020 SHALL implement FSM IDLE -> PENDING -> SWAP -> COPY -> IDLE.
REQ-021 SHALL drive host_wr_ready high only in IDLE, and write an accepted byte to the shadow bank at the next edge.
REQ-022 SHALL, in IDLE, on host_commit with host_len in 1..2**ADDR_BITS-1, latch host_len and enter PENDING.
REQ-023 SHALL, on host_commit with host_len = 0, pulse commit_err and remain in IDLE.
REQ-024 SHALL include a write accepted in the same cycle as host_commit in the commit.
REQ-025 SHALL ignore host_commit outside IDLE, with no commit_err.
REQ-026 SHALL detect wrap as rds_addr = 0 while the previous-cycle rds_addr != 0, sampled every cycle.
REQ-027 SHALL move PENDING -> SWAP on wrap; in SWAP (one cycle) SHALL toggle active_bank, load rds_msg_len from the latch, and pulse swap_done.
REQ-028 SHALL, in COPY, copy bytes 0..2**ADDR_BITS-1 from the new active bank to the new shadow bank, one byte per cycle, then return to IDLE.
REQ-029 SHALL hold commit_pending high exactly in PENDING.
REQ-030 SHALL leave rds_data sourced from the old bank up to and including the SWAP edge; the first new-bank data appears 1 cycle after active_bank toggles.

Reset
REQ-031 SHALL, on rst, set FSM=IDLE, active_bank=0, rds_msg_len=RDS_MSG_LEN, rds_data=0, host_wr_ready=0 during reset, all pulses=0, and the copy counter and previous-address register to 0.
REQ-032 SHALL NOT clear RAM contents on reset; a reset mid-PENDING or mid-COPY discards the commit and a partial copy remains in the shadow bank.

Configuration
REQ-033 SHALL, with RDS_MSG_READBACK_EN defined, add ports host_rd_addr (input, ADDR_BITS) and host_rd_data (output, 8), giving a registered 1-cycle read of the active bank.
REQ-034 SHALL, with RDS_MSG_READBACK_EN undefined, omit those ports and the second read path.

Structure
REQ-035 SHALL place the FSM state enum and the RDS_MSG_LEN default constant in package rds_pkg.
REQ-036 SHALL instantiate sub-module rds_msg_ram (one write port, two read ports) once per bank.

Verification
REQ-037 SHALL verify reset: after rst, rds_msg_len=52, active_bank=0, and commit_pending=0.
REQ-038 SHALL verify write/commit: write 0x41 at address 3, commit with len=13, drive the modulator through 12 -> 0; expect swap_done exactly once, active_bank=1, rds_msg_len=13, and rds_data=0x41 when rds_addr=3.
REQ-039 SHALL verify write blocking: host_wr_valid held during PENDING/COPY sees ready=0 and no shadow change; after 64 copy cycles ready=1.
REQ-040 SHALL verify commit errors: commit with len=0 pulses commit_err with no state change; a commit during PENDING is ignored.
REQ-041 SHALL verify reset recovery: asserting rst during COPY returns to IDLE with active_bank=0 and rds_msg_len=52.
REQ-042 SHALL verify that a modulator stuck at address 5 keeps commit_pending=1 indefinitely with no swap.
